// File: rtl/pattern_req_scheduler.sv
// pattern_req_scheduler: issues 64-bit word fetch requests for up to
// TAG_COUNT configured streams. Tags are arbitrated round-robin, and each
// tag is limited by a credit counter that is returned by downstream pops.
`timescale 1ns/1ps
module pattern_req_scheduler #(
  parameter int ADDR_WIDTH  = 48,
  parameter int TAG_COUNT   = 4,
  parameter int TAG_WIDTH   = $clog2(TAG_COUNT),
  parameter int CREDITS     = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [TAG_WIDTH-1:0]   cfg_tag,
  input  logic [ADDR_WIDTH-1:0]  cfg_base,
  input  logic [COUNT_WIDTH-1:0] cfg_words,
  input  logic                   start,
  input  logic [TAG_COUNT-1:0]   pop,
  input  logic                   req_stall,
  output logic                   req,
  output logic [TAG_WIDTH-1:0]   req_tag,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   credit_err
);

  localparam int CREDIT_WIDTH = $clog2(CREDITS) + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDITS);
  localparam logic [TAG_WIDTH-1:0]    LAST_TAG    = TAG_WIDTH'(TAG_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_reg;
  logic                   done_reg;
  logic                   credit_err_reg;
  logic [TAG_WIDTH-1:0]   last_grant_reg;

  logic [ADDR_WIDTH-1:0]   base_reg      [TAG_COUNT];
  logic [COUNT_WIDTH-1:0]  remaining_reg [TAG_COUNT];
  logic [COUNT_WIDTH-1:0]  offset_reg    [TAG_COUNT];
  logic [CREDIT_WIDTH-1:0] credit_reg    [TAG_COUNT];

  logic [TAG_COUNT-1:0] has_work;
  logic [TAG_COUNT-1:0] credit_full;
  logic [TAG_COUNT-1:0] eligible;
  logic [TAG_COUNT-1:0] issue;
  logic [TAG_COUNT-1:0] pop_err;

  logic                  grant_found;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  all_empty;
  logic                  all_full;

  // Per-tag status flags derived from the stream and credit registers.
  generate
    for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_status
      assign has_work[gi]    = (remaining_reg[gi] != '0);
      assign credit_full[gi] = (credit_reg[gi] == CREDIT_FULL);
      assign eligible[gi]    = (state_reg == RUN) && has_work[gi] && (credit_reg[gi] != '0);
      assign issue[gi]       = req && (grant_idx == TAG_WIDTH'(gi));
      // A pop on a full counter is only an error when no issue frees a slot.
      assign pop_err[gi]     = pop[gi] && !issue[gi] && credit_full[gi];
    end
  endgenerate

  assign all_empty = ~|has_work;
  assign all_full  = &credit_full;

  // Round-robin search starting one past the last issued tag, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= TAG_COUNT; k++) begin
      if (!grant_found && eligible[TAG_WIDTH'((int'(last_grant_reg) + k) % TAG_COUNT)]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_WIDTH'((int'(last_grant_reg) + k) % TAG_COUNT);
      end
    end
  end

  // Word offset scaled to bytes; overflow past ADDR_WIDTH wraps naturally.
  assign grant_addr = base_reg[grant_idx] + (ADDR_WIDTH'(offset_reg[grant_idx]) << 3);

  assign req        = rst && !req_stall && grant_found;
  assign req_tag    = req ? grant_idx : '0;
  assign req_addr   = req ? grant_addr : '0;
  assign busy       = rst && (state_reg != IDLE);
  assign done       = rst && done_reg;
  assign credit_err = credit_err_reg;

  // Control FSM with arbitration pointer, done pulse and sticky credit error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      done_reg       <= 1'b0;
      credit_err_reg <= 1'b0;
      last_grant_reg <= LAST_TAG;
    end else begin
      done_reg <= 1'b0;
      if (req) begin
        last_grant_reg <= grant_idx;
      end
      if (|pop_err) begin
        credit_err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (all_empty) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (all_full) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-tag stream position and credit counter.
  generate
    for (genvar gi = 0; gi < TAG_COUNT; gi++) begin : g_stream
      always_ff @(posedge clk) begin
        if (!rst) begin
          base_reg[gi]      <= '0;
          remaining_reg[gi] <= '0;
          offset_reg[gi]    <= '0;
          credit_reg[gi]    <= CREDIT_FULL;
        end else begin
          if ((state_reg == IDLE) && cfg_we && (cfg_tag == TAG_WIDTH'(gi))) begin
            base_reg[gi]      <= cfg_base;
            remaining_reg[gi] <= cfg_words;
            offset_reg[gi]    <= '0;
          end else if (issue[gi]) begin
            offset_reg[gi]    <= offset_reg[gi] + COUNT_WIDTH'(1);
            remaining_reg[gi] <= remaining_reg[gi] - COUNT_WIDTH'(1);
          end
          // Issue needs a non-zero credit and pop is capped at full, so
          // the counter never wraps; issue plus pop cancels out.
          if (issue[gi] && !pop[gi]) begin
            credit_reg[gi] <= credit_reg[gi] - CREDIT_WIDTH'(1);
          end else if (pop[gi] && !issue[gi] && !credit_full[gi]) begin
            credit_reg[gi] <= credit_reg[gi] + CREDIT_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: doc/pattern_req_scheduler.md
PATTERN_REQ_SCHEDULER -- requirements
Module: pattern_req_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 48, byte-address width of the memory request port.
REQ-002 SHALL have parameter TAG_COUNT, default 4, number of request streams, one per tag.
REQ-003 SHALL have parameter TAG_WIDTH, default log2(TAG_COUNT), tag field width.
REQ-004 SHALL have parameter CREDITS, default 8, per-tag limit on words issued but not yet consumed downstream.
REQ-005 SHALL have parameter COUNT_WIDTH, default 32, width of per-stream word counts.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port cfg_we  input  1  stream configuration write strobe.
REQ-009 SHALL have port cfg_tag  input  TAG_WIDTH  stream selected by cfg_we.
REQ-010 SHALL have port cfg_base  input  ADDR_WIDTH  stream base byte address.
REQ-011 SHALL have port cfg_words  input  COUNT_WIDTH  number of 64-bit words to fetch; 0 disables the stream.
REQ-012 SHALL have port start  input  1  begin issuing all configured streams.
REQ-013 SHALL have port pop  input  TAG_COUNT  per-tag credit return, one word consumed downstream.
REQ-014 SHALL have port req_stall  input  1  memory port cannot accept a request this cycle.
REQ-015 SHALL have port req  output  1  request valid.
REQ-016 SHALL have port req_tag  output  TAG_WIDTH  tag of the issued request.
REQ-017 SHALL have port req_addr  output  ADDR_WIDTH  byte address of the issued request.
REQ-018 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-019 SHALL have port done  output  1  one-cycle pulse on DRAIN-to-IDLE.
REQ-020 SHALL have port credit_err  output  1  sticky flag, pop on a tag with full credits.

Function
REQ-021 SHALL implement states IDLE, RUN and DRAIN.
REQ-022 SHALL, in IDLE, on cfg_we, load base[cfg_tag]=cfg_base, remaining[cfg_tag]=cfg_words, offset[cfg_tag]=0; cfg_we outside IDLE SHALL be ignored.
REQ-023 SHALL move IDLE->RUN on start; start in RUN or DRAIN SHALL be ignored.
REQ-024 SHALL treat tag t as eligible iff state is RUN, remaining[t]!=0 and credit[t]!=0.
REQ-025 SHALL assert req combinationally, in the same cycle, iff req_stall=0 and at least one tag is eligible; req SHALL be 0 whenever req_stall=1.
REQ-026 SHALL select among eligible tags round-robin, searching from last_grant+1 upward with wrap; last_grant SHALL update only on an issued request.
REQ-027 SHALL drive req_addr = base[t] + offset[t]*8, truncated modulo 2^ADDR_WIDTH; req_tag=t; req_addr and req_tag SHALL be 0 when req=0.
REQ-028 SHALL, on issue for tag t, increment offset[t], decrement remaining[t] and decrement credit[t], all at the next edge.
REQ-029 SHALL increment credit[t] on pop[t]; issue and pop on the same tag in the same cycle SHALL leave credit[t] unchanged.
REQ-030 SHALL ignore pop[t] when credit[t]==CREDITS with no issue on t, and set credit_err.
REQ-031 SHALL move RUN->DRAIN when every remaining[] is 0, including immediately after start when all streams are disabled.
REQ-032 SHALL move DRAIN->IDLE and pulse done for one cycle when every credit[] equals CREDITS.
REQ-033 SHALL accept pop in every state, so late credits return while in IDLE.
REQ-034 SHALL keep credit counters log2(CREDITS)+1 bits wide, with no wrap in either direction.

Reset
REQ-035 SHALL, on a clock edge with rst=0, set state=IDLE, every remaining/offset/base=0, every credit=CREDITS, last_grant=TAG_COUNT-1, credit_err=0.
REQ-036 SHALL hold req=0, busy=0, done=0 while rst=0; reset mid-RUN SHALL abandon all outstanding requests without a done pulse.

Verification
REQ-037 SHALL verify single stream: cfg tag1 base 0x1000 words 3, start, req_stall=0, pops=0 -> req at 0x1000, 0x1008, 0x1010 on consecutive cycles, then DRAIN; 3 pops on tag1 -> done pulse, IDLE.
REQ-038 SHALL verify round-robin: tags 0..3 each with words 2 and ample credits -> tag order 0,1,2,3,0,1,2,3.
REQ-039 SHALL verify credit limit: CREDITS=8, tag2 words 20, no pops -> exactly 8 requests, then req=0; one pop[2] -> exactly one more request.
REQ-040 SHALL verify stall: req_stall=1 for 5 cycles mid-stream -> req=0 throughout, no address skipped; same-cycle issue and pop on a tag -> credit unchanged.
REQ-041 SHALL verify boundaries: all words 0 with start -> DRAIN then done within 2 cycles; base 2^48-8 with words 2 -> addresses 0xFFFFFFFFFFF8 then 0x0.
REQ-042 SHALL verify reset: rst=0 mid-RUN -> next cycle IDLE, req=0, credits full; pop on idle tag with full credits -> credit_err=1 and held until reset.
